uart_stream_buffer: RTL and testbench

- Byte-stream buffer between host logic and the 921600-baud uart_s7 serial core.
- Decouples the host from uart_s7's unbuffered req/ack byte handshakes.
- TX FIFO feeds uart_s7's transmit port; RX FIFO drains uart_s7's receive port.
- Host side uses simple write-enable/read-enable strobes with full/empty status, so host code no longer has to keep up with each byte.

---
 rtl/uart_buf_pkg.sv | 7 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/uart_stream_buffer.sv | 113 +++++++++++
 tb/tb_uart_stream_buffer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_buf_pkg.sv
// Shared types for the uart_s7 byte-stream buffer.
package uart_buf_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_GAP} tx_state_t;
  typedef enum logic {RX_WAIT, RX_ACK} rx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead circular FIFO: a write is visible at the head one cycle later.
// A write while full or a read while empty is dropped; all status outputs come from registered state.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_100m,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge clk_100m) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_stream_buffer.sv
// Buffers host bytes to/from uart_s7's req/ack ports through two FIFOs.
// TX waits on uart_s7 ack; RX always acks and discards into a sticky overflow flag when full.
module uart_stream_buffer
  import uart_buf_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_100m,
  input  logic                  rst,
  input  logic                  tx_wr_en,
  input  logic [BYTE_W-1:0]     tx_wr_data,
  output logic                  tx_full,
  output logic [DEPTH_LOG2:0]   tx_count,
  input  logic                  rx_rd_en,
  output logic [BYTE_W-1:0]     rx_rd_data,
  output logic                  rx_empty,
  output logic [DEPTH_LOG2:0]   rx_count,
  output logic                  rx_overflow,
  input  logic                  ovf_clr,
  output logic [BYTE_W-1:0]     u_tx_byte,
  output logic                  u_tx_req,
  input  logic                  u_tx_ack,
  input  logic [BYTE_W-1:0]     u_rx_byte,
  input  logic                  u_rx_req,
  output logic                  u_rx_ack
);
  tx_state_t tx_state, tx_state_nxt;
  rx_state_t rx_state, rx_state_nxt;
  logic      tx_pop;
  logic      tx_empty;
  logic      rx_push;
  logic      rx_full;
  logic      ovf_set;
  logic      rx_ack_nxt;

  sync_fifo #(.WIDTH(BYTE_W), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk_100m (clk_100m),
    .rst      (rst),
    .wr_en    (tx_wr_en),
    .wr_data  (tx_wr_data),
    .rd_en    (tx_pop),
    .rd_data  (u_tx_byte),
    .full     (tx_full),
    .empty    (tx_empty),
    .count    (tx_count)
  );

  sync_fifo #(.WIDTH(BYTE_W), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk_100m (clk_100m),
    .rst      (rst),
    .wr_en    (rx_push),
    .wr_data  (u_rx_byte),
    .rd_en    (rx_rd_en),
    .rd_data  (rx_rd_data),
    .full     (rx_full),
    .empty    (rx_empty),
    .count    (rx_count)
  );

  assign u_tx_req = (tx_state == TX_REQ);

  // TX_GAP drops req for a cycle so a multi-cycle ack cannot pop twice.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_pop       = 1'b0;
    case (tx_state)
      TX_IDLE: if (!tx_empty) tx_state_nxt = TX_REQ;
      TX_REQ: begin
        if (u_tx_ack) begin
          tx_pop       = 1'b1;
          tx_state_nxt = TX_GAP;
        end
      end
      TX_GAP:  tx_state_nxt = TX_IDLE;
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  // Full check uses pre-pop state, so a same-cycle host pop does not save the byte.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_push      = 1'b0;
    ovf_set      = 1'b0;
    rx_ack_nxt   = 1'b0;
    case (rx_state)
      RX_WAIT: begin
        if (u_rx_req) begin
          rx_push      = !rx_full;
          ovf_set      = rx_full;
          rx_ack_nxt   = 1'b1;
          rx_state_nxt = RX_ACK;
        end
      end
      RX_ACK:  if (!u_rx_req) rx_state_nxt = RX_WAIT;
      default: rx_state_nxt = RX_WAIT;
    endcase
  end

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      tx_state    <= TX_IDLE;
      rx_state    <= RX_WAIT;
      u_rx_ack    <= 1'b0;
      rx_overflow <= 1'b0;
    end else begin
      tx_state <= tx_state_nxt;
      rx_state <= rx_state_nxt;
      u_rx_ack <= rx_ack_nxt;
      if (ovf_set)      rx_overflow <= 1'b1;
      else if (ovf_clr) rx_overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_stream_buffer.sv
// Self-checking bench: uart_s7 req/ack models plus TX/RX byte scoreboards.
module tb_uart_stream_buffer;
  localparam int DL = 4;

  logic          clk_100m = 1'b0;
  logic          rst;
  logic          tx_wr_en;
  logic [7:0]    tx_wr_data;
  logic          tx_full;
  logic [DL:0]   tx_count;
  logic          rx_rd_en;
  logic [7:0]    rx_rd_data;
  logic          rx_empty;
  logic [DL:0]   rx_count;
  logic          rx_overflow;
  logic          ovf_clr;
  logic [7:0]    u_tx_byte;
  logic          u_tx_req;
  logic          u_tx_ack;
  logic [7:0]    u_rx_byte;
  logic          u_rx_req;
  logic          u_rx_ack;

  uart_stream_buffer #(.DEPTH_LOG2(DL)) dut (
    .clk_100m    (clk_100m),
    .rst         (rst),
    .tx_wr_en    (tx_wr_en),
    .tx_wr_data  (tx_wr_data),
    .tx_full     (tx_full),
    .tx_count    (tx_count),
    .rx_rd_en    (rx_rd_en),
    .rx_rd_data  (rx_rd_data),
    .rx_empty    (rx_empty),
    .rx_count    (rx_count),
    .rx_overflow (rx_overflow),
    .ovf_clr     (ovf_clr),
    .u_tx_byte   (u_tx_byte),
    .u_tx_req    (u_tx_req),
    .u_tx_ack    (u_tx_ack),
    .u_rx_byte   (u_rx_byte),
    .u_rx_req    (u_rx_req),
    .u_rx_ack    (u_rx_ack)
  );

  always #5 clk_100m = ~clk_100m;

  typedef struct {
    logic [7:0]  data;
    logic        accept;
    logic [DL:0] exp_count;
    logic        exp_full;
  } tx_vec_t;

  tx_vec_t    vecs [17];
  logic [7:0] t1_bytes [3];
  logic [7:0] tx_q [$];
  logic [7:0] rx_q [$];
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         tx_model_en = 1'b0;
  int         tx_wait  = 0;
  int         tx_sent  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100m);
    #1;
  endtask

  // uart_s7 transmit side: acks a pending request after a few cycles, one-cycle pulse.
  initial begin
    u_tx_ack = 1'b0;
    forever begin
      @(posedge clk_100m);
      #1;
      if (u_tx_ack) begin
        u_tx_ack = 1'b0;
      end else if (tx_model_en && u_tx_req && !rst) begin
        if (tx_wait >= 3) begin
          u_tx_ack = 1'b1;
          tx_wait  = 0;
          tx_sent++;
          if (tx_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_unexpected: got byte %02h, required no byte", u_tx_byte);
          end else begin
            check("tx_byte", u_tx_byte, tx_q.pop_front());
          end
        end else begin
          tx_wait++;
        end
      end else begin
        tx_wait = 0;
      end
    end
  end

  task automatic wait_sent(input int target, input string name);
    int n = 0;
    while (tx_sent < target && n < 2000) begin
      tick();
      n++;
    end
    check(name, tx_sent, target);
  endtask

  // uart_s7 receive side: holds req until one cycle after it sees ack.
  task automatic rx_deliver(input logic [7:0] b, output int ack_cycles);
    int n = 0;
    u_rx_byte = b;
    u_rx_req  = 1'b1;
    while (!u_rx_ack && n < 20) begin
      tick();
      n++;
    end
    ack_cycles = 0;
    if (!u_rx_ack) begin
      n_checks++;
      n_fail++;
      $display("FAIL rx_ack_timeout: u_rx_ack=0 after %0d cycles, required 1", n);
    end else begin
      ack_cycles = 1;
      tick();
      if (u_rx_ack) ack_cycles++;
    end
    u_rx_req = 1'b0;
    tick();
  endtask

  task automatic rx_drain(input string name);
    int n = rx_q.size();
    for (int i = 0; i < n; i++) begin
      check(name, rx_rd_data, rx_q.pop_front());
      rx_rd_en = 1'b1;
      tick();
      rx_rd_en = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int ac;
    int base;
    rst = 1'b1; tx_wr_en = 1'b0; tx_wr_data = '0; rx_rd_en = 1'b0;
    ovf_clr = 1'b0; u_rx_byte = '0; u_rx_req = 1'b0;
    t1_bytes[0] = 8'h55; t1_bytes[1] = 8'hA3; t1_bytes[2] = 8'h00;
    for (int i = 0; i < 17; i++) begin
      vecs[i].data      = 8'h10 + 8'(i);
      vecs[i].accept    = (i < 16);
      vecs[i].exp_count = (i < 16) ? (DL + 1)'(i + 1) : (DL + 1)'(16);
      vecs[i].exp_full  = (i >= 15);
    end

    repeat (2) tick();
    check("rst_tx_full", tx_full, 0);
    check("rst_tx_count", tx_count, 0);
    check("rst_rx_empty", rx_empty, 1);
    check("rst_rx_count", rx_count, 0);
    check("rst_rx_overflow", rx_overflow, 0);
    check("rst_u_tx_req", u_tx_req, 0);
    check("rst_u_rx_ack", u_rx_ack, 0);
    rst = 1'b0;
    tick();

    // 1: three bytes leave in order
    tx_model_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_wr_data = t1_bytes[i];
      tx_wr_en   = 1'b1;
      tx_q.push_back(t1_bytes[i]);
      tick();
      if (i == 0) check("t1_req_same_edge", u_tx_req, 0);
      if (i == 1) check("t1_req_next_edge", u_tx_req, 1);
    end
    tx_wr_en = 1'b0;
    wait_sent(3, "t1_sent");
    repeat (3) tick();
    check("t1_tx_count", tx_count, 0);
    check("t1_tx_req_idle", u_tx_req, 0);

    // 2: fill to 17 with uart stalled
    tx_model_en = 1'b0;
    repeat (2) tick();
    base = tx_sent;
    for (int i = 0; i < 17; i++) begin
      tx_wr_data = vecs[i].data;
      tx_wr_en   = 1'b1;
      if (vecs[i].accept) tx_q.push_back(vecs[i].data);
      tick();
      check("t2_tx_count", tx_count, vecs[i].exp_count);
      check("t2_tx_full", tx_full, vecs[i].exp_full);
    end
    tx_wr_en    = 1'b0;
    tx_model_en = 1'b1;
    wait_sent(base + 16, "t2_sent16");
    repeat (40) tick();
    check("t2_no_extra_byte", tx_sent, base + 16);
    check("t2_queue_empty", tx_q.size(), 0);
    check("t2_tx_count_end", tx_count, 0);

    // 3: single RX byte
    rx_deliver(8'h3C, ac);
    check("t3_ack_one_cycle", ac, 1);
    check("t3_rx_count", rx_count, 1);
    check("t3_rx_head", rx_rd_data, 8'h3C);
    rx_rd_en = 1'b1;
    tick();
    rx_rd_en = 1'b0;
    check("t3_rx_empty", rx_empty, 1);

    // 4: overflow, set beats clear, discard on full+pop
    for (int i = 0; i < 16; i++) begin
      rx_deliver(8'h80 + 8'(i), ac);
      rx_q.push_back(8'h80 + 8'(i));
    end
    check("t4_rx_count16", rx_count, 16);
    check("t4_no_ovf_yet", rx_overflow, 0);
    u_rx_byte = 8'hFF; u_rx_req = 1'b1; ovf_clr = 1'b1;
    tick();
    check("t4_ovf_set_wins", rx_overflow, 1);
    check("t4_ack_on_discard", u_rx_ack, 1);
    ovf_clr = 1'b0;
    tick();
    u_rx_req = 1'b0;
    tick();
    check("t4_count_after_discard", rx_count, 16);
    check("t4_ovf_sticky", rx_overflow, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t4_ovf_cleared", rx_overflow, 0);
    check("t4_head_before_pop", rx_rd_data, rx_q.pop_front());
    u_rx_byte = 8'hEE; u_rx_req = 1'b1; rx_rd_en = 1'b1;
    tick();
    rx_rd_en = 1'b0;
    check("t4_fullpop_ovf", rx_overflow, 1);
    check("t4_fullpop_count", rx_count, 15);
    tick();
    u_rx_req = 1'b0;
    tick();
    check("t4_no_double_push", rx_count, 15);
    rx_drain("t4_drain");
    check("t4_rx_empty", rx_empty, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;

    // 5: simultaneous push/pop at count 5, then pop on empty
    for (int i = 0; i < 5; i++) begin
      rx_deliver(8'h40 + 8'(i), ac);
      rx_q.push_back(8'h40 + 8'(i));
    end
    check("t5_count5", rx_count, 5);
    check("t5_head", rx_rd_data, rx_q.pop_front());
    u_rx_byte = 8'h45; u_rx_req = 1'b1; rx_rd_en = 1'b1;
    rx_q.push_back(8'h45);
    tick();
    rx_rd_en = 1'b0;
    check("t5_count_same", rx_count, 5);
    tick();
    u_rx_req = 1'b0;
    tick();
    rx_drain("t5_drain");
    rx_rd_en = 1'b1;
    tick();
    rx_rd_en = 1'b0;
    check("t5_empty_rd_count", rx_count, 0);
    check("t5_empty_rd_empty", rx_empty, 1);

    // 6: async reset mid-transaction
    tx_model_en = 1'b0;
    for (int i = 0; i < 4; i++) rx_deliver(8'h60 + 8'(i), ac);
    tx_wr_data = 8'h77; tx_wr_en = 1'b1;
    tick();
    tx_wr_en = 1'b0;
    tick();
    check("t6_req_pending", u_tx_req, 1);
    check("t6_rx_count4", rx_count, 4);
    #2 rst = 1'b1;
    #1;
    check("t6_async_tx_req", u_tx_req, 0);
    check("t6_async_rx_empty", rx_empty, 1);
    check("t6_async_tx_count", tx_count, 0);
    tx_q.delete();
    tick();
    rst = 1'b0;
    tick();
    tx_model_en = 1'b1;
    base = tx_sent;
    tx_wr_data = 8'h5A; tx_wr_en = 1'b1;
    tx_q.push_back(8'h5A);
    tick();
    tx_wr_en = 1'b0;
    wait_sent(base + 1, "t6_sent_after_rst");
    repeat (5) tick();
    check("t6_tx_count_end", tx_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
